// File: rtl/dram_access_sequencer.sv
// Bridges single-cycle load/store strobes onto a word-wide, byte-strobed memory port.
// Accesses that straddle a word boundary become two beats; load data is aligned and extended.
module dram_access_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_we,
    input  logic              i_le,
    input  logic [2:0]        i_ctrl,
    output logic              o_busy,
    output logic [31:0]       o_odata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    localparam logic [ADDR_W-3:0] WORD_ONE = 1;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        ctrl_reg;
    logic              we_reg;
    logic [31:0]       rdata0_reg;
    logic [31:0]       odata_reg;

    logic [1:0]  off;
    logic [7:0]  size_mask;
    logic [7:0]  strb_wide;
    logic [63:0] wdata_wide;
    logic        split;
    logic        strobe;
    logic        load_done;
    logic [63:0] rd_pair;
    logic [31:0] rd_raw;
    logic [31:0] rd_masked;
    logic [31:0] lane_mask;
    logic        fill;
    logic [31:0] load_result;

    assign strobe = i_le | i_we;
    assign off    = addr_reg[1:0];

    // Lane mask of the access at offset 0; shifting by the offset spills
    // any second-word lanes into the upper nibble.
    always_comb begin
        case (ctrl_reg[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
    end

    assign strb_wide  = size_mask << off;
    assign wdata_wide = {32'h0, wdata_reg} << {off, 3'b000};
    assign split      = |strb_wide[7:4];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (strobe) begin
                    state_next = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (m_ack) begin
                    state_next = split ? S_BEAT1 : S_IDLE;
                end
            end
            S_BEAT1: begin
                if (m_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Beat outputs are decoded from registered state only, so they stay stable while m_req is high.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = 32'h0;
        m_wstrb = 4'h0;
        case (state_reg)
            S_BEAT0: begin
                m_req   = 1'b1;
                m_we    = we_reg;
                m_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
                m_wdata = wdata_wide[31:0];
                m_wstrb = strb_wide[3:0];
            end
            S_BEAT1: begin
                m_req   = 1'b1;
                m_we    = we_reg;
                m_addr  = {addr_reg[ADDR_W-1:2] + WORD_ONE, 2'b00};
                m_wdata = wdata_wide[63:32];
                m_wstrb = strb_wide[7:4];
            end
            default: ;
        endcase
    end

    // Load alignment: the second word's low bytes follow the first word's high bytes.
    assign rd_pair = (state_reg == S_BEAT1) ? {m_rdata, rdata0_reg} : {32'h0, m_rdata};
    assign rd_raw  = 32'(rd_pair >> {off, 3'b000});

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{size_mask[gi]}};
            assign rd_masked[8*gi +: 8] = size_mask[gi] ? rd_raw[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        case (ctrl_reg[1:0])
            2'd0:    fill = rd_raw[7];
            2'd1:    fill = rd_raw[15];
            default: fill = 1'b0;
        endcase
    end

    assign load_result = rd_masked | ({32{fill & ~ctrl_reg[2]}} & ~lane_mask);
    assign load_done   = m_ack & ~we_reg &
                         (((state_reg == S_BEAT0) & ~split) | (state_reg == S_BEAT1));

    // Access capture and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            ctrl_reg   <= 3'h0;
            we_reg     <= 1'b0;
            rdata0_reg <= 32'h0;
            odata_reg  <= 32'h0;
        end else begin
            if ((state_reg == S_IDLE) && strobe) begin
                addr_reg  <= i_addr;
                wdata_reg <= i_wdata;
                ctrl_reg  <= i_ctrl;
                we_reg    <= i_we;
            end
            if ((state_reg == S_BEAT0) && m_ack) begin
                rdata0_reg <= m_rdata;
            end
            if (load_done) begin
                odata_reg <= load_result;
            end
        end
    end

    assign o_odata = odata_reg;
    assign o_busy  = (state_reg != S_IDLE) | strobe;

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Self-checking bench for dram_access_sequencer: directed vector table, reset corner case,
// then randomized accesses checked against a byte-level reference model.
module tb_dram_access_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic        i_le;
    logic [2:0]  i_ctrl;
    logic        o_busy;
    logic [31:0] o_odata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dram_access_sequencer #(.ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we), .i_le(i_le), .i_ctrl(i_ctrl),
        .o_busy(o_busy), .o_odata(o_odata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        le;
        logic [2:0]  ctrl;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          delay;
        logic [31:0] exp_odata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] ctrl);
        return (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    endfunction

    // Reference load: gather each byte from whichever word holds it, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] ctrl,
                                               input logic [31:0] rd0, input logic [31:0] rd1);
        int          nb = size_bytes(ctrl);
        logic [31:0] first_word = addr & 32'hFFFF_FFFC;
        logic [31:0] val = 32'h0;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba = addr + i;
            logic [31:0] word = ((ba & 32'hFFFF_FFFC) == first_word) ? rd0 : rd1;
            val[8*i +: 8] = word[8*ba[1:0] +: 8];
        end
        if (!ctrl[2] && nb < 4 && val[8*nb-1]) begin
            val = val | ~((32'h1 << (8*nb)) - 32'h1);
        end
        return val;
    endfunction

    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic we, input logic le, input logic [2:0] ctrl,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input int delay, input logic [31:0] exp_odata);
        logic [31:0] b_addr[2];
        logic [3:0]  b_strb[2];
        logic [31:0] b_data[2];
        int          nbeats = 0;
        int          nb = size_bytes(ctrl);
        logic        stable;
        // Expected beats: walk the touched bytes and group them by word address.
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba = addr + i;
            if (nbeats == 0 || b_addr[nbeats-1] != (ba & 32'hFFFF_FFFC)) begin
                b_addr[nbeats] = ba & 32'hFFFF_FFFC;
                b_strb[nbeats] = 4'h0;
                b_data[nbeats] = 32'h0;
                nbeats++;
            end
            b_strb[nbeats-1][ba[1:0]] = 1'b1;
            b_data[nbeats-1][8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end

        @(negedge CLK);
        i_addr = addr; i_wdata = wdata; i_we = we; i_le = le; i_ctrl = ctrl;
        #1 check("busy_on_strobe", {31'h0, o_busy}, 32'h1);
        @(negedge CLK);
        i_we = 1'b0; i_le = 1'b0;
        i_addr = $urandom; i_wdata = $urandom; i_ctrl = 3'($urandom);
        for (int b = 0; b < nbeats; b++) begin
            check("beat_req", {31'h0, m_req}, 32'h1);
            check("beat_we", {31'h0, m_we}, {31'h0, we});
            check("beat_addr", m_addr, b_addr[b]);
            check("beat_strb", {28'h0, m_wstrb}, {28'h0, b_strb[b]});
            if (we) check("beat_wdata", m_wdata, b_data[b]);
            stable = 1'b1;
            for (int d = 0; d < delay; d++) begin
                @(negedge CLK);
                if (m_req !== 1'b1 || m_addr !== b_addr[b] || m_wstrb !== b_strb[b] || o_busy !== 1'b1)
                    stable = 1'b0;
            end
            check("beat_hold", {31'h0, stable}, 32'h1);
            m_ack = 1'b1;
            m_rdata = (b == 0) ? rd0 : rd1;
            @(negedge CLK);
            m_ack = 1'b0;
            m_rdata = $urandom;
        end
        check("done_req", {31'h0, m_req}, 32'h0);
        check("done_busy", {31'h0, o_busy}, 32'h0);
        check("done_odata", o_odata, exp_odata);
        $display("TXN addr=%h we=%0d le=%0d ctrl=%0d beats=%0d odata=%h exp=%h",
                 addr, we, le, ctrl, nbeats, o_odata, exp_odata);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] last_load;
        vecs[0] = '{32'h0000_0100, 32'h0,         1'b0, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0,         0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0203, 32'h0,         1'b0, 1'b1, 3'b000, 32'h8012_3456, 32'h0,         0, 32'hFFFF_FF80};
        vecs[2] = '{32'h0000_0203, 32'h0,         1'b0, 1'b1, 3'b100, 32'h8012_3456, 32'h0,         1, 32'h0000_0080};
        vecs[3] = '{32'h0000_0301, 32'h1122_3344, 1'b1, 1'b0, 3'b010, 32'h0,         32'h0,         0, 32'h0000_0080};
        vecs[4] = '{32'h0000_0403, 32'h0,         1'b0, 1'b1, 3'b001, 32'hAB00_0000, 32'h0000_00CD, 0, 32'hFFFF_CDAB};
        vecs[5] = '{32'h0000_0500, 32'hCAFE_F00D, 1'b1, 1'b1, 3'b010, 32'h0,         32'h0,         5, 32'hFFFF_CDAB};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 3'b001, 32'h7F00_0000, 32'h0000_0012, 2, 32'h0000_127F};
        vecs[7] = '{32'h0000_0602, 32'h0,         1'b0, 1'b1, 3'b011, 32'h4433_2211, 32'h8877_6655, 0, 32'h6655_4433};
        vecs[8] = '{32'h0000_0702, 32'h0,         1'b0, 1'b1, 3'b001, 32'h8001_0000, 32'h0,         0, 32'hFFFF_8001};

        RST = 1'b1; i_addr = 32'h0; i_wdata = 32'h0; i_we = 1'b0; i_le = 1'b0; i_ctrl = 3'h0;
        m_ack = 1'b0; m_rdata = 32'h0;
        repeat (3) @(negedge CLK);
        check("rst_req", {31'h0, m_req}, 32'h0);
        check("rst_addr", m_addr, 32'h0);
        check("rst_strb", {28'h0, m_wstrb}, 32'h0);
        check("rst_odata", o_odata, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        RST = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_access(vecs[v].addr, vecs[v].wdata, vecs[v].we, vecs[v].le, vecs[v].ctrl,
                       vecs[v].rd0, vecs[v].rd1, vecs[v].delay, vecs[v].exp_odata);
        end

        // Reset while the second beat of a split load is outstanding
        @(negedge CLK);
        i_addr = 32'h0000_0801; i_le = 1'b1; i_ctrl = 3'b010;
        @(negedge CLK);
        i_le = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        @(negedge CLK);
        m_ack = 1'b0;
        check("mid_beat1_req", {31'h0, m_req}, 32'h1);
        check("mid_beat1_addr", m_addr, 32'h0000_0804);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_req", {31'h0, m_req}, 32'h0);
        check("mid_rst_odata", o_odata, 32'h0);
        check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        m_ack = 1'b0;
        @(negedge CLK);
        check("late_ack_req", {31'h0, m_req}, 32'h0);
        check("late_ack_odata", o_odata, 32'h0);
        $display("TXN reset during second beat, late ack ignored odata=%h", o_odata);

        last_load = 32'h0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] rd0 = $urandom;
            logic [31:0] rd1 = $urandom;
            logic        we = 1'($urandom_range(0, 1));
            logic        le = we ? 1'($urandom_range(0, 1)) : 1'b1;
            logic [2:0]  ctrl = 3'($urandom_range(0, 7));
            int          delay = $urandom_range(0, 3);
            if (n % 8 == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            if (!we) last_load = model_load(addr, ctrl, rd0, rd1);
            run_access(addr, wdata, we, le, ctrl, rd0, rd1, delay, last_load);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_access_sequencer.md
# dram_access_sequencer

Sits between the bus arbiter's shared DRAM port (`w_dram_addr/wdata/we_t/le/ctrl`, consuming `w_dram_busy/odata`) and the word-wide memory controller. It latches a single-cycle load/store strobe from the granted core and issues byte-strobed word beats, splitting accesses that cross a 32-bit boundary into two beats. It also aligns and sign/zero-extends load data and holds busy until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32: address width.

Ports:
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `i_addr` in 32: byte address, sampled on strobe.
- `i_wdata` in 32: store data, LSB-aligned, sampled on strobe.
- `i_we` in 1: one-cycle store strobe (arbiter `w_dram_we_t`).
- `i_le` in 1: one-cycle load strobe (arbiter `w_dram_le`).
- `i_ctrl` in 3: [1:0] size (0 byte, 1 half, 2 word, 3 treated as word); [2] 1 = zero-extend load.
- `o_busy` out 1: access in progress (feeds arbiter `w_dram_busy`).
- `o_odata` out 32: load result (feeds arbiter `w_dram_odata`).
- `m_req` out 1: beat request to controller.
- `m_we` out 1: beat is a write.
- `m_addr` out 32: word-aligned beat address ([1:0]=0).
- `m_wdata` out 32: beat write data, byte lanes positioned.
- `m_wstrb` out 4: byte-lane enables.
- `m_ack` in 1: one-cycle beat completion; `m_rdata` valid same cycle.
- `m_rdata` in 32: beat read data.

## Operation
- States: IDLE, BEAT0, BEAT1.
- IDLE: on `i_le|i_we`, capture addr, wdata, ctrl, kind (`i_we` wins if both high; `i_le` dropped); off = addr[1:0]; nbytes = 1/2/4; split = off+nbytes > 4; go BEAT0.
- BEAT0: `m_req`=1, `m_addr`={addr[31:2],2'b00}; `m_wstrb` = ((1<<nbytes)-1)<<off truncated to 4 bits; `m_wdata` = wdata<<(8*off). On `m_ack`: store rdata0; go BEAT1 if split, else finish.
- BEAT1: `m_addr` = beat0 addr + 4 (wraps at 2^32); `m_wstrb` = ((1<<nbytes)-1)>>(4-off); `m_wdata` = wdata>>(8*(4-off)). On `m_ack`: finish.
- Finish (loads): raw = (rdata0>>8*off) | (split ? rdata1<<8*(4-off) : 0); mask to nbytes; sign-extend from bit 8*nbytes-1 unless ctrl[2]; register into `o_odata`; return IDLE.
- Finish (stores): `o_odata` unchanged; return IDLE.
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb` stable while `m_req`=1; all zero in IDLE.
- `m_ack` in IDLE ignored; strobes outside IDLE ignored (upstream must wait for busy low).
- `o_busy` = (state != IDLE) | i_le | i_we (combinational so the core sees busy on the strobe cycle).

## Timing
- Reset: state IDLE; `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_wstrb`, `o_odata` = 0; `o_busy` = 0 unless a strobe is present.
- Reset mid-access: abandon beat, `m_req` drops next cycle, `o_odata` cleared; a late `m_ack` is ignored.
- Strobe at cycle 0 → `m_req` high cycle 1.
- `m_req` holds until the cycle `m_ack` is seen; the request drops or the address advances the next cycle.
- Single-beat access, ack at cycle k → busy low and `o_odata` valid at k+1. Minimum busy: cycles 0–1.
- Split access: BEAT1 `m_req` at cycle k0+1 after first ack k0; busy low the cycle after second ack.
- `o_odata` holds until the next load completes.

## Test plan
- Word load addr 0x100, `m_rdata`=0xDEADBEEF, ack cycle 1 → `m_addr`=0x100, strb 1111, `o_odata`=0xDEADBEEF cycle 2, busy high cycles 0–1 only.
- Signed byte load addr 0x203, rdata 0x80xxxxxx → `o_odata`=0xFFFFFF80; same with ctrl[2]=1 → 0x00000080.
- Word store addr 0x301, wdata 0x11223344 → beat0 addr 0x300 strb 1110 wdata 0x22334400; beat1 addr 0x304 strb 0001 wdata 0x00000011; busy low after second ack.
- Half load addr 0x403, rdata0 0xAB000000, rdata1 0x000000CD → `o_odata`=0xFFFFCDAB.
- `i_le` and `i_we` together at addr 0x500 → single write beat only; ack held off 5 cycles → `m_req`/addr stable, busy high throughout.
- `RST` asserted during BEAT1 → next cycle `m_req`=0, `o_odata`=0, state IDLE; `m_ack` pulse after reset causes no change.
